// File: rtl/countdown_pkg.sv
// Shared types and default constants for the countdown timer.
// State encoding and parameter defaults live here so the top and any
// future register-file wrapper agree on them.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } cd_state_e;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned TICK_DIV_DEF   = 100_000_000;
    localparam int unsigned WARN_LEVEL_DEF = 5;

endpackage

// File: rtl/tick_gen.sv
// Tick divider for the countdown timer.
// Counts enabled cycles and pulses tick combinationally on the DIV-th one.
// Holding enable low freezes the phase, and clear restarts it from zero.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    assign tick = enable && (cnt_q == TERM);

    // Phase counter: clear wins over counting, and it wraps at the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_p.sv
// Countdown timer with pause/resume, abort and an early-warning output.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When it is defined, an
// auto_reload input is added, and expiry reloads the last started value
// instead of stopping.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | stopped; remaining holds 0 after expiry/abort
// ST_RUN   | divider running, remaining decrements per tick
// ST_PAUSE | divider phase and remaining frozen
// ST_DONE  | single cycle after natural expiry (done high)
module countdown_timer_p
    import countdown_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
    parameter int unsigned WARN_LEVEL = WARN_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] time_in,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic             auto_reload,
`endif
    output logic [CNT_W-1:0] remaining,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             warn
);

    localparam logic [CNT_W-1:0] WARN_L = CNT_W'(WARN_LEVEL);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    cd_state_e        state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             running_q, running_d;
    logic             paused_q, paused_d;
    logic             done_q, done_d;
    logic             warn_q, warn_d;
    logic             div_en, div_clr, tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [CNT_W-1:0] reload_q, reload_d;
`endif

    assign div_en = (state_q == ST_RUN);

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (div_en),
        .clear  (div_clr),
        .tick   (tick)
    );

    // Next-state and output decode; abort beats start, which beats pause.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_clr = 1'b0;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (abort) begin
            if (state_q == ST_RUN || state_q == ST_PAUSE) begin
                state_d = ST_IDLE;
                rem_d   = '0;
                div_clr = 1'b1;
            end else if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (start) begin
            rem_d   = time_in;
            div_clr = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = time_in;
`endif
            if (time_in == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // Expiry check uses <= 1 so remaining can never wrap below 0.
                    if (tick && rem_q <= ONE) begin
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (auto_reload) begin
                            rem_d   = reload_q;
                            div_clr = 1'b1;
                        end else begin
                            rem_d   = '0;
                            state_d = ST_DONE;
                        end
`else
                        rem_d   = '0;
                        state_d = ST_DONE;
`endif
                    end else begin
                        if (tick) begin
                            rem_d = rem_q - ONE;
                        end
                        if (pause) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
        warn_d    = (state_d == ST_RUN || state_d == ST_PAUSE) &&
                    (rem_d != '0) && (rem_d <= WARN_L);
    end

    // State, count and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            warn_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            done_q    <= done_d;
            warn_q    <= warn_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign remaining = rem_q;
    assign running   = running_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign warn      = warn_q;

endmodule

// File: tb/tb_countdown_timer_p.sv
// Testbench for countdown_timer_p (TICK_DIV=4, CNT_W=8, WARN_LEVEL=2).
// Expected outputs come from a deadline-based timer model and are queued per
// cycle. A separate monitor compares them against the DUT on the falling edge.
module tb_countdown_timer_p;

    localparam int CW  = 8;
    localparam int DIV = 4;
    localparam int WL  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] time_in;
    logic          start, pause, abort;
    logic          ar;
    logic [CW-1:0] remaining;
    logic          running, paused, done, warn;

    countdown_timer_p #(.CNT_W(CW), .TICK_DIV(DIV), .WARN_LEVEL(WL)) dut (
        .clk       (clk),
        .rst       (rst),
        .time_in   (time_in),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        .auto_reload (ar),
`endif
        .remaining (remaining),
        .running   (running),
        .paused    (paused),
        .done      (done),
        .warn      (warn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] rem;
        logic          run;
        logic          pau;
        logic          dn;
        logic          wr;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: absolute edge number of the next tick, plus the cycles still
    // owed to it while paused.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_e;
    mmode_e m_mode = M_IDLE;
    int m_rem = 0, m_deadline = 0, m_left = 0, m_reload = 0, m_edge = 0;
    bit m_pulse = 0;

    function automatic void chk(string nm, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    task automatic model_step(input bit s, input bit p, input bit a, input int t, input bit arl);
        bit expired;
        m_edge++;
        m_pulse = 0;
        expired = 0;
        if (rst) begin
            m_mode = M_IDLE; m_rem = 0; m_reload = 0;
        end else if (a) begin
            if (m_mode == M_RUN || m_mode == M_PAUSE) begin
                m_mode = M_IDLE; m_rem = 0;
            end else if (m_mode == M_DONE) begin
                m_mode = M_IDLE;
            end
        end else if (s) begin
            m_reload = t;
            m_rem = t;
            if (t == 0) begin
                m_mode = M_DONE; m_pulse = 1;
            end else begin
                m_mode = M_RUN; m_deadline = m_edge + DIV;
            end
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (m_edge == m_deadline) begin
                        m_rem--;
                        m_deadline = m_edge + DIV;
                        if (m_rem == 0) begin
                            expired = 1; m_pulse = 1;
                            if (arl) m_rem = m_reload;
                            else m_mode = M_DONE;
                        end
                    end
                    if (p && !expired) begin
                        m_left = m_deadline - m_edge;
                        m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (p) begin
                    m_deadline = m_edge + m_left;
                    m_mode = M_RUN;
                end
                M_DONE: m_mode = M_IDLE;
                default: ;
            endcase
        end
    endtask

    task automatic push_expected();
        snap_t e;
        e.rem = CW'(m_rem);
        e.run = (m_mode == M_RUN);
        e.pau = (m_mode == M_PAUSE);
        e.dn  = m_pulse;
        e.wr  = (m_mode == M_RUN || m_mode == M_PAUSE) && m_rem > 0 && m_rem <= WL;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit s, input bit p, input bit a, input int t);
        start = s; pause = p; abort = a; time_in = CW'(t);
        @(posedge clk);
        #1;
        model_step(s, p, a, t, ar);
        push_expected();
        start = 0; pause = 0; abort = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Monitor: one snapshot per cycle, compared away from the rising edge.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("remaining", int'(remaining), int'(e.rem));
                chk("running",   int'(running),   int'(e.run));
                chk("paused",    int'(paused),    int'(e.pau));
                chk("done",      int'(done),      int'(e.dn));
                chk("warn",      int'(warn),      int'(e.wr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 0; pause = 0; abort = 0; time_in = '0; ar = 0;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        rst = 1'b0;
        idle(2);

        // Basic countdown from 3, then expiry and IDLE.
        cycle(1, 0, 0, 3); idle(20);
        // Zero load goes straight to DONE.
        cycle(1, 0, 0, 0); idle(4);
        // Pause two cycles after the first tick, resume ten cycles later.
        cycle(1, 0, 0, 5); idle(5); cycle(0, 1, 0, 0); idle(9); cycle(0, 1, 0, 0); idle(30);
        // Abort and start together during RUN.
        cycle(1, 0, 0, 6); idle(5); cycle(1, 0, 1, 9); idle(3);
        // Restart during RUN with 9.
        cycle(1, 0, 0, 7); idle(6); cycle(1, 0, 0, 9); idle(45);
        // Warning window.
        cycle(1, 0, 0, 4); idle(25);
        // Reset mid-count: no done afterwards.
        cycle(1, 0, 0, 6); idle(7); mid_reset(); idle(30);
        // Abort while paused.
        cycle(1, 0, 0, 5); idle(3); cycle(0, 1, 0, 0); idle(3); cycle(0, 0, 1, 0); idle(5);
        // Pause in IDLE is ignored.
        cycle(0, 1, 0, 0); idle(3);
        // Pause coincident with the final tick: expiry wins.
        cycle(1, 0, 0, 1); idle(3); cycle(0, 1, 0, 0); idle(4);
        // Pause coincident with a non-final tick: decrement then pause.
        cycle(1, 0, 0, 3); idle(3); cycle(0, 1, 0, 0); idle(3); cycle(0, 1, 0, 0); idle(20);
        // Largest load value stays in range.
        cycle(1, 0, 0, 255); idle(12); cycle(0, 0, 1, 0); idle(2);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        ar = 1;
        cycle(1, 0, 0, 2); idle(40);
        ar = 0;
        idle(20);
`endif
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit s, p, a;
            s = ($urandom % 25) == 0;
            p = ($urandom % 10) == 0;
            a = ($urandom % 40) == 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            if (($urandom % 50) == 0) ar = ~ar;
`endif
            if (($urandom % 400) == 0) mid_reset();
            else cycle(s, p, a, int'($urandom % 8));
        end
        idle(3);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer_p.md
COUNTDOWN_TIMER_P -- requirements
Module: countdown_timer_p

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the loaded time value and the remaining count.
REQ-002 SHALL have parameter TICK_DIV, default 100_000_000, clock cycles per count tick (must be at least 2).
REQ-003 SHALL have parameter WARN_LEVEL, default 5, remaining-count threshold for the warning output.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port time_in, input, CNT_W bits: load value, sampled on an accepted start.
REQ-007 SHALL have port start, input, 1 bit: single-cycle load and run request.
REQ-008 SHALL have port pause, input, 1 bit: single-cycle pause/resume toggle request.
REQ-009 SHALL have port abort, input, 1 bit: single-cycle cancel request.
REQ-010 SHALL have port remaining, output, CNT_W bits: current count, registered.
REQ-011 SHALL have port running, output, 1 bit: high in RUN.
REQ-012 SHALL have port paused, output, 1 bit: high in PAUSE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on natural expiry only.
REQ-014 SHALL have port warn, output, 1 bit: high in RUN/PAUSE while 0 < remaining <= WARN_LEVEL.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-016 SHALL treat request priority as abort > start > pause when they occur in the same cycle.
REQ-017 SHALL, on start in any state, load remaining = time_in, clear the tick divider and enter RUN on the next edge; start in RUN/PAUSE restarts the count.
REQ-018 SHALL, on start with time_in == 0, go to DONE on the next edge, with remaining = 0.
REQ-019 SHALL run the tick divider only in RUN; it pulses once per TICK_DIV cycles, and the first tick occurs TICK_DIV cycles after entering RUN.
REQ-020 SHALL decrement remaining by 1 on each tick in RUN; when a tick takes remaining from 1 to 0, SHALL enter DONE on the same edge.
REQ-021 SHALL assert done for exactly one cycle (the DONE state), then return to IDLE holding remaining = 0.
REQ-022 SHALL, on pause in RUN, enter PAUSE, freezing both remaining and the divider phase; pause in PAUSE returns to RUN and continues the same phase; pause in IDLE or DONE is ignored.
REQ-023 SHALL, on a pause coincident with a tick, apply the decrement first and then pause; if that decrement reaches 0, enter DONE and ignore the pause.
REQ-024 SHALL, on abort in RUN or PAUSE, enter IDLE with remaining = 0, clear the divider, and produce no done pulse; abort in IDLE or DONE leaves state unchanged.
REQ-025 SHALL never let remaining wrap below 0.

Reset
REQ-026 SHALL, while rst is high, force: state IDLE, remaining 0, divider 0, and running, paused, done and warn all 0.
REQ-027 SHALL, if reset is asserted mid-count, abandon the count with no done pulse after release.

Configuration
REQ-028 SHALL, when COUNTDOWN_AUTO_RELOAD_EN is defined, add input port auto_reload (1 bit) and hold the last accepted time_in in a reload register.
REQ-029 SHALL, with COUNTDOWN_AUTO_RELOAD_EN defined and auto_reload high at expiry, pulse done for one cycle and reload remaining from the reload register on the expiry edge; it SHALL stay in RUN with the divider cleared.
REQ-030 SHALL, without COUNTDOWN_AUTO_RELOAD_EN, have no auto_reload port and always stop at expiry per REQ-020/021.

Structure
REQ-031 SHALL place the state enum type and the default parameter constants in package countdown_pkg.
REQ-032 SHALL implement the divider as sub-module tick_gen, with ports clk, rst, enable, clear and tick, and parameter DIV.

Verification (TICK_DIV=4, CNT_W=8, WARN_LEVEL=2)
REQ-033 SHALL test: start with time_in=3 -> remaining 3, 2, 1, 0 at 4-cycle spacing; done high for 1 cycle; then IDLE.
REQ-034 SHALL test: start with time_in=0 -> DONE on the next edge, done pulse, no RUN cycle.
REQ-035 SHALL test: time_in=5, pause 2 cycles after the first tick, resume 10 cycles later -> remaining frozen at 4, and the next tick arrives 2 cycles after resume.
REQ-036 SHALL test: abort and start in the same cycle during RUN -> IDLE, remaining 0, no done pulse; start alone during RUN with time_in=9 -> remaining 9, divider restarted.
REQ-037 SHALL test: time_in=4 -> warn low at 4 and 3, high at 2 and 1, low at 0 and in IDLE.
REQ-038 SHALL test: with COUNTDOWN_AUTO_RELOAD_EN and auto_reload=1, time_in=2 -> done pulses every 8 cycles; remaining goes 2, 1, 2, 1 ...; running stays high.
